// File: rtl/mac_accumulator_if.sv
// Handshake bundle for the MAC accumulate stage: product stream in, window result out.
// The accumulator uses the slave view; the feeding datapath / consumer side uses master.
interface mac_accumulator_if #(
   parameter int PW = 14,
   parameter int OW = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [PW-1:0] in_prod;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_data;
   logic                 out_sat;

   modport master (
      output in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/mac_accumulator.sv
// Signed windowed accumulator: sums LEN products per window into a double-buffered result.
// Optional saturation of the window sum to OW bits is enabled by MAC_ACCUMULATOR_SAT_EN.
module mac_accumulator #(
   parameter int PW  = 14,
   parameter int AW  = 24,
   parameter int OW  = 16,
   parameter int LEN = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   mac_accumulator_if.slave bus
);
   localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(LEN - 1);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] sum;
   logic [CW-1:0]        cnt;
   logic                 last_beat;
   logic                 accept;
   logic                 load;
   logic signed [OW-1:0] fmt_data;
   logic                 fmt_sat;
   logic signed [OW-1:0] out_data_q;
   logic                 out_sat_q;
   logic                 out_valid_q;

   assign prod_ext  = AW'(bus.in_prod);
   assign sum       = acc + prod_ext;
   assign last_beat = (cnt == LAST);

   // Only the closing beat of a window can be held off by an unconsumed result.
   assign bus.in_ready = ~clr & ~(last_beat & out_valid_q & ~bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;
   assign load         = accept & last_beat;

`ifdef MAC_ACCUMULATOR_SAT_EN
   localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) <<< (OW - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

   always_comb begin
      fmt_data = sum[OW-1:0];
      fmt_sat  = 1'b0;
      if (sum > SAT_MAX) begin
         fmt_data = SAT_MAX[OW-1:0];
         fmt_sat  = 1'b1;
      end else if (sum < SAT_MIN) begin
         fmt_data = SAT_MIN[OW-1:0];
         fmt_sat  = 1'b1;
      end
   end
`else
   always_comb begin
      fmt_data = sum[OW-1:0];
      fmt_sat  = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (last_beat) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + CW'(1);
         end
      end
   end

   // A fresh result wins over a same-cycle consume, keeping out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= fmt_data;
         out_sat_q   <= fmt_sat;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed windows plus random traffic against a queue-based window model.
module tb_mac_accumulator;
   localparam int PW  = 14;
   localparam int AW  = 24;
   localparam int OW  = 16;
   localparam int LEN = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;

   mac_accumulator_if #(.PW(PW), .OW(OW)) bus ();

   mac_accumulator #(.PW(PW), .AW(AW), .OW(OW), .LEN(LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: the products accepted so far in the open window, and the result register.
   int            q_win[$];
   bit            m_valid;
   logic [OW-1:0] m_data;
   bit            m_sat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      q_win.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_sat   = 1'b0;
   endtask

   task automatic m_finish_window();
      int s;
      s = 0;
      foreach (q_win[i]) s += q_win[i];
`ifdef MAC_ACCUMULATOR_SAT_EN
      if (s > (2 ** (OW - 1)) - 1) begin
         s     = (2 ** (OW - 1)) - 1;
         m_sat = 1'b1;
      end else if (s < -(2 ** (OW - 1))) begin
         s     = -(2 ** (OW - 1));
         m_sat = 1'b1;
      end else begin
         m_sat = 1'b0;
      end
`else
      m_sat = 1'b0;
`endif
      m_data = s[OW-1:0];
      q_win.delete();
   endtask

   // Starts and ends at posedge+1: drive, check in_ready at negedge, advance model at posedge.
   task automatic step(input bit v, input int prod, input bit c, input bit ordy);
      bit exp_rdy;
      bit take;
      bit load;
      bus.in_valid  = v;
      bus.in_prod   = PW'(prod);
      clr           = c;
      bus.out_ready = ordy;
      exp_rdy = !c && !((q_win.size() == LEN - 1) && m_valid && !ordy);
      @(negedge clk);
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      take = v && exp_rdy;
      @(posedge clk);
      load = 1'b0;
      if (c) begin
         q_win.delete();
      end else if (take) begin
         q_win.push_back(prod);
         if (q_win.size() == LEN) begin
            m_finish_window();
            load = 1'b1;
         end
      end
      if (load) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
      #1;
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("out_data", {16'd0, bus.out_data}, {16'd0, m_data});
      check("out_sat", {31'd0, bus.out_sat}, {31'd0, m_sat});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_prod   = '0;
      bus.out_ready = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
      check("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rst_n = 1'b1;

      // basic sum
      repeat (LEN) step(1'b1, 100, 1'b0, 1'b1);
      check("basic_valid", {31'd0, bus.out_valid}, 32'd1);
      check("basic_data", {16'd0, bus.out_data}, 32'd900);
      idle(1);
      check("basic_pulse", {31'd0, bus.out_valid}, 32'd0);

      // negative extreme
      repeat (LEN) step(1'b1, -8192, 1'b0, 1'b1);
`ifdef MAC_ACCUMULATOR_SAT_EN
      check("neg_data", {16'd0, bus.out_data}, 32'h8000);
      check("neg_sat", {31'd0, bus.out_sat}, 32'd1);
`else
      check("neg_data", {16'd0, bus.out_data}, 32'hE000);
      check("neg_sat", {31'd0, bus.out_sat}, 32'd0);
`endif
      idle(1);

      // backpressure: beat 18 stalls until out_ready pulses
      repeat (2 * LEN - 1) step(1'b1, 1, 1'b0, 1'b0);
      check("bp_held", {16'd0, bus.out_data}, 32'd9);
      check("bp_stall", {31'd0, bus.in_ready}, 32'd0);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 1, 1'b0, 1'b1);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data", {16'd0, bus.out_data}, 32'd9);
      idle(1);

      // abort with clr; the +7 alongside clr is dropped
      repeat (4) step(1'b1, 50, 1'b0, 1'b1);
      step(1'b1, 7, 1'b1, 1'b1);
      repeat (LEN) step(1'b1, 2, 1'b0, 1'b1);
      check("abort_data", {16'd0, bus.out_data}, 32'd18);
      idle(1);

      // async reset mid-window with a pending result
      repeat (LEN) step(1'b1, 1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      m_reset();
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_data", {16'd0, bus.out_data}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (LEN) step(1'b1, 3, 1'b0, 1'b1);
      check("post_rst_data", {16'd0, bus.out_data}, 32'd27);
      idle(1);

      // last beat coincides with consume of the pending result
      repeat (LEN) step(1'b1, 4, 1'b0, 1'b0);
      repeat (LEN - 1) step(1'b1, 5, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b1);
      check("simul_valid", {31'd0, bus.out_valid}, 32'd1);
      check("simul_data", {16'd0, bus.out_data}, 32'd45);
      idle(1);

      // random traffic
      for (int k = 0; k < 600; k++) begin
         step(($urandom % 4) != 0,
              int'($urandom_range(0, 16383)) - 8192,
              ($urandom % 25) == 0,
              ($urandom % 3) != 0);
      end
      // skewed toward large same-sign products to exercise clipping
      for (int k = 0; k < 200; k++) begin
         step(1'b1,
              (($urandom % 2) != 0) ? int'($urandom_range(6000, 8191)) : -int'($urandom_range(6000, 8192)),
              1'b0,
              ($urandom % 2) != 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Signed accumulate stage placed directly downstream of the `wallace_gen` multiplier in the CNN datapath. It consumes one signed product per accepted beat, sums a fixed-length window of LEN products (one convolution kernel), and presents the window result on a registered, handshaked output. A second output register lets the next window accumulate while the previous result waits for the consumer.

## Interface
- `PW`, 14: product width in bits, signed two's complement; equals N+W-1 of the feeding multiplier.
- `AW`, 24: accumulator width in bits; must satisfy AW >= PW + clog2(LEN).
- `OW`, 16: output data width in bits; OW <= AW.
- `LEN`, 9: number of products per window; LEN >= 1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous window abort.
- `in_valid`  in  1  product valid.
- `in_ready`  out  1  product accepted when `in_valid & in_ready`.
- `in_prod`  in  PW  signed product.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_data`  out  OW  signed window sum.
- `out_sat`  out  1  result was clipped.

## Operation
- Internal state:
  - `acc` (AW bits, signed).
  - `cnt` (0..LEN-1): products accepted in the current window.
  - Output register: `out_data`, `out_sat`, `out_valid`.
- Each accepted product is sign-extended to AW bits and added to `acc`.
- Accepting a product with `cnt < LEN-1`: `acc <= acc + ext(in_prod)`, `cnt <= cnt + 1`.
- Accepting a product with `cnt == LEN-1` (last beat):
  - Output register loads `fmt(acc + ext(in_prod))`.
  - `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- `fmt` is defined under Configuration.
- LEN == 1: every accepted beat is a last beat.
- Output handshake:
  - `out_valid` clears when `out_ready` is high and no new result loads in the same cycle.
  - If a new result loads in the same cycle as `out_ready`, `out_valid` stays 1 and the data is replaced.
- `in_ready = ~clr & ~(cnt == LEN-1 & out_valid & ~out_ready)`.
  - Stalls occur only on the last beat of a window while the previous result is still unconsumed.
  - Non-last beats are never stalled by the output side.
- `clr`:
  - Forces `acc <= 0`, `cnt <= 0`.
  - `in_ready` is 0 that cycle, so a product presented alongside `clr` is not accepted.
  - The output register and `out_valid` are unaffected.
- Accumulator overflow cannot occur when the AW rule holds; behaviour with AW too small is unspecified.

## Timing
- Reset values: `acc=0`, `cnt=0`, `out_valid=0`, `out_data=0`, `out_sat=0`, `in_ready=1` (while `clr`=0).
- Latency: last product accepted at edge t gives `out_valid=1` and valid `out_data` after edge t, i.e. visible in cycle t+1.
- Throughput: one product per cycle sustained when `out_ready` is 1 at least once per LEN cycles.
- `in_ready` is combinational from `clr`, `out_ready` and state; there is no combinational path from `in_valid` to any output.
- Reset asserted mid-window discards the partial sum and any pending result immediately (asynchronous).

## Configuration
- Macro: `MAC_ACCUMULATOR_SAT_EN`.
- Defined:
  - `fmt` saturates the AW-bit sum to the signed OW-bit range [-2^(OW-1), 2^(OW-1)-1].
  - `out_sat=1` when clipping occurred.
- Undefined:
  - `fmt` is truncation: `out_data = sum[OW-1:0]` (wrap-around).
  - `out_sat` is tied to 0.
  - No comparator logic is built.

## Test plan
All scenarios use the defaults PW=14, AW=24, OW=16, LEN=9.
- **Basic sum:** 9 back-to-back products of +100 with `out_ready=1` -> `out_valid` pulses 1 cycle after the 9th beat, `out_data=900`, `out_sat=0`.
- **Negative extreme:** 9 products of -8192 (0x2000) -> with the macro, `out_data=0x8000` and `out_sat=1`; without it, `out_data=0xE000` and `out_sat=0`.
- **Backpressure:** 18 consecutive products of +1, `out_ready=0` -> first result 9 is held; `in_ready` drops on beat 18 only; raising `out_ready` for 1 cycle lets beat 18 in the same cycle, then `out_data=9` again with `out_valid=1` continuously.
- **Abort:** 4 products of +50, then `clr` for 1 cycle with `in_valid=1` and `in_prod=+7`, then 9 products of +2 -> the +7 is not accepted; result is `out_data=18`.
- **Reset mid-operation:** `rst_n` low after 5 beats while a prior result is pending -> `out_valid=0`, `out_data=0` immediately; the next 9 beats of +3 yield 27.
- **Simultaneous events:** result pending, 9th beat of the next window arrives in the same cycle as `out_ready=1` -> beat accepted, `out_valid` stays 1, `out_data` updates to the new sum on the next edge.
